// File: rtl/vec_regprog_sequencer_if.sv
// Bundle of loader, operand and result handshake signals for vec_regprog_sequencer.
// The master drives programs, operands and out_ready; the slave (the sequencer) drives the results.
interface vec_regprog_sequencer_if #(
    parameter int W  = 16,
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_wdata;
    logic          start;
    logic [AW:0]   prog_len;
    logic [W-1:0]  a1;
    logic [W-1:0]  a0;
    logic [W-1:0]  b1;
    logic [W-1:0]  b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y3;
    logic [W-1:0]  y2;
    logic [W-1:0]  y1;
    logic [W-1:0]  y0;
    logic [AW:0]   insn_count;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, prog_len,
        output a1, a0, b1, b0, out_ready,
        input  busy, out_valid, y3, y2, y1, y0, insn_count
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, prog_len,
        input  a1, a0, b1, b0, out_ready,
        output busy, out_valid, y3, y2, y1, y0, insn_count
    );
endinterface

// File: rtl/vec_regprog_sequencer.sv
// Sequenced register-transfer engine: runs a loadable straight-line program of bitwise ops
// over four W-bit registers, one instruction per clock, and hands results off via valid/ready.
module vec_regprog_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic                    clk,
    input logic                    rst,
    vec_regprog_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LNOT = 3'd5;
    localparam logic [2:0] OP_BNOT = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [7:0]    store_reg [DEPTH];
    logic [W-1:0]  r_reg     [4];
    logic [W-1:0]  r_next    [4];
    logic [W-1:0]  opnd_reg  [4];
    logic [W-1:0]  y_reg     [4];
    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] pc_reg;
    logic [AW:0]   len_reg, count_reg, len_clamped;

    logic [7:0]    insn;
    logic [2:0]    op;
    logic [1:0]    dst;
    logic [2:0]    src;
    logic [W-1:0]  s_val, d_val, res;
    logic          wr_en, last;
    logic          start_ok, accept;

    // Store is a reset-cleared register file so every run sees NOPs unless loaded.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_store
        always_ff @(posedge clk) begin
            if (rst)
                store_reg[gi] <= 8'h00;
            else if (state_reg == ST_IDLE && bus.prog_we && bus.prog_addr == AW'(gi))
                store_reg[gi] <= bus.prog_wdata;
        end
    end

    assign len_clamped = (bus.prog_len > DEPTH_V) ? DEPTH_V : bus.prog_len;
    assign start_ok    = (state_reg == ST_IDLE) && bus.start;
    assign accept      = (state_reg == ST_DONE) && bus.out_ready;

    assign insn  = store_reg[pc_reg];
    assign op    = insn[7:5];
    assign dst   = insn[4:3];
    assign src   = insn[2:0];
    // Sources 4..7 select the operand latches (a0, a1, b0, b1), not the live inputs.
    assign s_val = src[2] ? opnd_reg[src[1:0]] : r_reg[src[1:0]];
    assign d_val = r_reg[dst];
    assign wr_en = (op != OP_NOP) && (op != OP_HALT);
    assign last  = (op == OP_HALT) || ({1'b0, pc_reg} == len_reg - 1'b1);

    always_comb begin
        res = d_val;
        case (op)
            OP_MOV:  res = s_val;
            OP_AND:  res = d_val & s_val;
            OP_OR:   res = d_val | s_val;
            OP_XOR:  res = d_val ^ s_val;
            OP_LNOT: res = (s_val == '0) ? W'(1) : '0;
            OP_BNOT: res = ~s_val;
            default: res = d_val;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) r_next[i] = r_reg[i];
        if (start_ok) begin
            r_next[0] = bus.a0;
            r_next[1] = bus.a1;
            r_next[2] = bus.b0;
            r_next[3] = bus.b1;
        end else if (state_reg == ST_RUN && wr_en) begin
            r_next[dst] = res;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = (len_clamped == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last)      state_next = ST_DONE;
            ST_DONE: if (accept)    state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                r_reg[i]    <= '0;
                opnd_reg[i] <= '0;
                y_reg[i]    <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < 4; i++) r_reg[i] <= r_next[i];
            if (start_ok) begin
                opnd_reg[0] <= bus.a0;
                opnd_reg[1] <= bus.a1;
                opnd_reg[2] <= bus.b0;
                opnd_reg[3] <= bus.b1;
                pc_reg      <= '0;
                count_reg   <= '0;
                len_reg     <= len_clamped;
            end else if (state_reg == ST_RUN) begin
                count_reg <= count_reg + 1'b1;
                if (!last) pc_reg <= pc_reg + 1'b1;
            end
            // Results are snapshotted on DONE entry so y* never shows intermediate values.
            if (state_next == ST_DONE && state_reg != ST_DONE)
                for (int i = 0; i < 4; i++) y_reg[i] <= r_next[i];
        end
    end

    assign bus.busy       = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    assign bus.out_valid  = (state_reg == ST_DONE);
    assign bus.y0         = y_reg[0];
    assign bus.y1         = y_reg[1];
    assign bus.y2         = y_reg[2];
    assign bus.y3         = y_reg[3];
    assign bus.insn_count = count_reg;
endmodule

// File: tb/tb_vec_regprog_sequencer.sv
// Directed bench for vec_regprog_sequencer: hand-computed programs, latency, hold, reset abort.
module tb_vec_regprog_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vec_regprog_sequencer_if #(.W(16), .AW(4)) bus ();

    vec_regprog_sequencer #(.W(16), .DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = addr;
        bus.prog_wdata = data;
        tick();
        bus.prog_we    = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e0, e1, e2, e3, input int ecnt);
        chk({tag, ".y0"}, 32'(bus.y0), 32'(e0));
        chk({tag, ".y1"}, 32'(bus.y1), 32'(e1));
        chk({tag, ".y2"}, 32'(bus.y2), 32'(e2));
        chk({tag, ".y3"}, 32'(bus.y3), 32'(e3));
        chk({tag, ".cnt"}, 32'(bus.insn_count), 32'(ecnt));
    endtask

    // Start a run (optionally with a simultaneous store write to addr 0), wait for out_valid,
    // check latency and results, then accept them.
    task automatic run(input string tag, input int len,
                       input logic [15:0] va0, va1, vb0, vb1,
                       input bit we, input logic [7:0] wd, input int en,
                       input logic [15:0] e0, e1, e2, e3);
        int n;
        bus.start      = 1'b1;
        bus.prog_len   = 5'(len);
        bus.a0         = va0;
        bus.a1         = va1;
        bus.b0         = vb0;
        bus.b1         = vb1;
        bus.prog_we    = we;
        bus.prog_addr  = 4'd0;
        bus.prog_wdata = wd;
        tick();
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        bus.a0 = 16'hDEAD; bus.a1 = 16'hDEAD; bus.b0 = 16'hDEAD; bus.b1 = 16'hDEAD;
        n = 0;
        while (!bus.out_valid && n < 64) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(en));
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check_outs(tag, e0, e1, e2, e3, en);
        $display("run %s: lat=%0d y0=%h y1=%h y2=%h y3=%h cnt=%0d", tag, n,
                 bus.y0, bus.y1, bus.y2, bus.y3, bus.insn_count);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".vld_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
        bus.start = 1'b0; bus.prog_len = '0; bus.out_ready = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.vld", 32'(bus.out_valid), 32'd0);
        check_outs("rst", 16'h0, 16'h0, 16'h0, 16'h0, 0);

        // T1: AND r1,b0 ; XOR r3,r0
        load(4'd0, 8'h4E);
        load(4'd1, 8'h98);
        run("t1", 2, 16'h0FF0, 16'h1234, 16'h00FF, 16'hFFFF, 1'b0, 8'h00, 2,
            16'h0FF0, 16'h0034, 16'h00FF, 16'hF00F);

        // T2: LNOT r2,b0 loaded in the same cycle as start, then rerun
        run("t2a", 1, 16'h0FF0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 8'hB6, 1,
            16'h0FF0, 16'h1234, 16'h0001, 16'hFFFF);
        run("t2b", 1, 16'h0FF0, 16'h1234, 16'h0005, 16'hFFFF, 1'b0, 8'h00, 1,
            16'h0FF0, 16'h1234, 16'h0000, 16'hFFFF);

        // T3: HALT stops the run; trailing BNOT r2,r0 never executes
        load(4'd0, 8'h24);
        load(4'd1, 8'hE0);
        load(4'd2, 8'hD0);
        load(4'd3, 8'hD0);
        run("t3", 4, 16'hAAAA, 16'h5555, 16'h1357, 16'h2468, 1'b0, 8'h00, 2,
            16'hAAAA, 16'h5555, 16'h1357, 16'h2468);

        // T4: zero-length program
        run("t4", 0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 8'h00, 0,
            16'd1, 16'd2, 16'd3, 16'd4);

        // T5: start/prog_we in RUN and DONE ignored, outputs held while out_ready low
        load(4'd0, 8'h4E);
        load(4'd1, 8'h98);
        bus.start = 1'b1; bus.prog_len = 5'd2;
        bus.a0 = 16'h0FF0; bus.a1 = 16'h1234; bus.b0 = 16'h00FF; bus.b1 = 16'hFFFF;
        tick();
        bus.prog_len = 5'd1; bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_wdata = 8'hE0;
        tick();
        tick();
        chk("t5.vld", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5.hold_vld", 32'(bus.out_valid), 32'd1);
            check_outs("t5.hold", 16'h0FF0, 16'h0034, 16'h00FF, 16'hF00F, 2);
        end
        $display("run t5: held 5 cycles y1=%h y3=%h cnt=%0d", bus.y1, bus.y3, bus.insn_count);
        bus.start = 1'b0; bus.prog_we = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t5.vld_clr", 32'(bus.out_valid), 32'd0);
        run("t5.rerun", 2, 16'h0FF0, 16'h1234, 16'h00FF, 16'hFFFF, 1'b0, 8'h00, 2,
            16'h0FF0, 16'h0034, 16'h00FF, 16'hF00F);

        // T6: reset in mid-run clears state, outputs and store
        bus.start = 1'b1; bus.prog_len = 5'd8;
        bus.a0 = 16'h1111; bus.a1 = 16'h2222; bus.b0 = 16'h3333; bus.b1 = 16'h4444;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.busy", 32'(bus.busy), 32'd0);
        chk("t6.vld", 32'(bus.out_valid), 32'd0);
        check_outs("t6.rst", 16'h0, 16'h0, 16'h0, 16'h0, 0);
        $display("run t6: reset mid-run busy=%0d vld=%0d", bus.busy, bus.out_valid);
        run("t6.after", 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 8'h00, 4,
            16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // prog_len above DEPTH clamps to DEPTH executed NOPs
        run("clamp", 31, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0, 8'h00, 16,
            16'h0001, 16'h0002, 16'h0004, 16'h0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
